// File: rtl/fetch_stage_pkg.sv
// Shared RV32I pipeline types and constants.
// Imported by the fetch stage, its skid buffer and the imem bus interface.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    FLUSH = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus.
// The master issues requests; the slave accepts them and returns data.
interface fetch_stage_if;
  import riscv_pkg::*;

  logic            IMemReq;
  logic [XLEN-1:0] IMemAddr;
  logic            IMemReady;
  logic            IMemRespValid;
  logic [XLEN-1:0] IMemRdata;

  modport master (
    output IMemReq,
    output IMemAddr,
    input  IMemReady,
    input  IMemRespValid,
    input  IMemRdata
  );

  modport slave (
    input  IMemReq,
    input  IMemAddr,
    output IMemReady,
    output IMemRespValid,
    output IMemRdata
  );

endinterface

// File: rtl/fetch_stage_skid_buffer.sv
// One-entry {pc, instr} holding slot for a response that
// arrives while the IF/ID registers are stalled and occupied.
module fetch_skid_buffer
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            unload,
  input  logic            clear,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_instr,
  output logic            valid,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid     <= 1'b0;
      out_pc    <= '0;
      out_instr <= NOP_INSTR;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid     <= 1'b1;
      out_pc    <= in_pc;
      out_instr <= in_instr;
    end else if (unload) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC, one-outstanding imem
// request FSM and the IF/ID output registers.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = riscv_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Stall,
  input  logic              Redirect,
  input  logic [XLEN-1:0]   RedirectPC,
  fetch_stage_if.master     imem,
  output logic              IF_Valid,
  output logic [XLEN-1:0]   IF_PC,
  output logic [XLEN-1:0]   IF_PCPlus4,
  output logic [XLEN-1:0]   IF_Instr
);

  localparam logic [2:0] S_BOOT  = 3'(BOOT);
  localparam logic [2:0] S_REQ   = 3'(REQ);
  localparam logic [2:0] S_WAIT  = 3'(WAIT);
  localparam logic [2:0] S_HOLD  = 3'(HOLD);
  localparam logic [2:0] S_FLUSH = 3'(FLUSH);

  logic [2:0]      state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic            resp;
  logic            slot_free;
  logic            owed;
  logic            skid_load;
  logic            skid_unload;
  logic            skid_valid;
  logic [XLEN-1:0] skid_pc;
  logic [XLEN-1:0] skid_instr;

  assign imem.IMemReq  = (state == S_REQ);
  assign imem.IMemAddr = pc;

  assign pc_plus4  = pc + 32'd4;
  assign resp      = imem.IMemRespValid;
  assign slot_free = !IF_Valid || !Stall;

  // A response is still in flight and must be drained before refetching
  assign owed = (state == S_REQ   && imem.IMemReady)
             || (state == S_WAIT  && !resp)
             || (state == S_FLUSH && !resp);

  assign skid_load   = !Redirect && state == S_WAIT
                    && resp && !slot_free;
  assign skid_unload = !Redirect && state == S_HOLD
                    && !Stall && skid_valid;

  fetch_skid_buffer u_skid (
    .clk       (clk),
    .rst       (rst),
    .load      (skid_load),
    .unload    (skid_unload),
    .clear     (Redirect),
    .in_pc     (pc),
    .in_instr  (imem.IMemRdata),
    .valid     (skid_valid),
    .out_pc    (skid_pc),
    .out_instr (skid_instr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_BOOT;
      pc         <= RESET_PC;
      IF_Valid   <= 1'b0;
      IF_PC      <= '0;
      IF_PCPlus4 <= '0;
      IF_Instr   <= NOP_INSTR;
    end else if (Redirect) begin
      pc       <= RedirectPC & ~32'h3;
      IF_Valid <= 1'b0;
      IF_Instr <= NOP_INSTR;
      state    <= owed ? S_FLUSH : S_REQ;
    end else begin
      if (!Stall)
        IF_Valid <= 1'b0;
      unique case (1'b1)
        (state == S_BOOT): state <= S_REQ;
        (state == S_REQ): begin
          if (imem.IMemReady)
            state <= S_WAIT;
        end
        (state == S_WAIT): begin
          if (resp) begin
            pc <= pc_plus4;
            if (slot_free) begin
              IF_Valid   <= 1'b1;
              IF_PC      <= pc;
              IF_PCPlus4 <= pc_plus4;
              IF_Instr   <= imem.IMemRdata;
              state      <= S_REQ;
            end else begin
              state <= S_HOLD;
            end
          end
        end
        (state == S_HOLD): begin
          if (!Stall) begin
            if (skid_valid) begin
              IF_Valid   <= 1'b1;
              IF_PC      <= skid_pc;
              IF_PCPlus4 <= skid_pc + 32'd4;
              IF_Instr   <= skid_instr;
            end
            state <= S_REQ;
          end
        end
        (state == S_FLUSH): begin
          if (resp)
            state <= S_REQ;
        end
        default: state <= S_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random traffic,
// checked against a program-order instruction stream model.
module tb_fetch_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        Stall;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        IF_Valid;
  logic [31:0] IF_PC;
  logic [31:0] IF_PCPlus4;
  logic [31:0] IF_Instr;

  fetch_stage_if bus ();

  fetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .Stall      (Stall),
    .Redirect   (Redirect),
    .RedirectPC (RedirectPC),
    .imem       (bus),
    .IF_Valid   (IF_Valid),
    .IF_PC      (IF_PC),
    .IF_PCPlus4 (IF_PCPlus4),
    .IF_Instr   (IF_Instr)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Expected program-order PCs the decode stage should consume
  logic [31:0] exp_q[$];
  logic [31:0] fill_pc;

  logic        mem_out;
  logic [31:0] mem_addr;
  int          mem_cnt;
  int          mem_lat;
  logic        prev_pend;
  logic [31:0] prev_addr;
  int          pops = 0;
  int          idle = 0;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    if (a == 32'h0)
      return 32'h0010_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, sample mid-cycle, advance past the edge
  task automatic drive(input logic st, input logic rd,
                       input logic [31:0] rpc, input logic rdy);
    logic acc, rv, req;
    logic [31:0] addr;
    Stall             = st;
    Redirect          = rd;
    RedirectPC        = rpc;
    bus.IMemReady     = rdy;
    bus.IMemRespValid = 1'b0;
    bus.IMemRdata     = $urandom;
    if (mem_out) begin
      if (mem_cnt == 0) begin
        bus.IMemRespValid = 1'b1;
        bus.IMemRdata     = memfn(mem_addr);
      end else begin
        mem_cnt--;
      end
    end
    if (rst) begin
      exp_q.delete();
      fill_pc = RESET_PC;
    end else if (rd) begin
      exp_q.delete();
      fill_pc = rpc & ~32'h3;
    end
    while (exp_q.size() < 4) begin
      exp_q.push_back(fill_pc);
      fill_pc = fill_pc + 32'd4;
    end
    @(negedge clk);
    req  = bus.IMemReq;
    addr = bus.IMemAddr;
    acc  = req && rdy;
    rv   = bus.IMemRespValid;
    if (rst)
      chk("req_in_reset", 32'(req), 32'h0);
    if (req)
      chk("addr_align", 32'(addr[1:0]), 32'h0);
    if (prev_pend && !rst) begin
      chk("req_hold", 32'(req), 32'h1);
      chk("addr_hold", addr, prev_addr);
    end
    prev_pend = req && !rdy && !rd && !rst;
    prev_addr = addr;
    @(posedge clk);
    #1;
    if (rv)
      mem_out = 1'b0;
    if (acc) begin
      chk("one_outstanding", 32'(mem_out), 32'h0);
      mem_out  = 1'b1;
      mem_addr = addr;
      mem_cnt  = mem_lat - 1;
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      idle = 0;
    end else if (IF_Valid && !Stall && !Redirect) begin
      idle = 0;
      pops++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL stream: consumed pc %h, none expected", IF_PC);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("if_pc", IF_PC, e);
        chk("if_pcplus4", IF_PCPlus4, e + 32'd4);
        chk("if_instr", IF_Instr, memfn(e));
      end
    end else begin
      idle++;
      if (idle == 300) begin
        vectors++;
        miscompares++;
        $display("FAIL progress: %0d idle cycles, need < 300", idle);
      end
    end
  end

  initial begin
    logic st, rd, rdy;
    logic [31:0] rpc;
    rst               = 1'b1;
    Stall             = 1'b0;
    Redirect          = 1'b0;
    RedirectPC        = 32'h0;
    bus.IMemReady     = 1'b0;
    bus.IMemRespValid = 1'b0;
    bus.IMemRdata     = 32'h0;
    mem_out   = 1'b0;
    mem_addr  = 32'h0;
    mem_cnt   = 0;
    mem_lat   = 1;
    prev_pend = 1'b0;
    prev_addr = 32'h0;
    fill_pc   = RESET_PC;

    drive(1'b0, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    chk("rst_valid", 32'(IF_Valid), 32'h0);
    chk("rst_pc", IF_PC, 32'h0);
    chk("rst_pc4", IF_PCPlus4, 32'h0);
    chk("rst_instr", IF_Instr, NOP_INSTR);
    chk("rst_req", 32'(bus.IMemReq), 32'h0);

    // First fetch from RESET_PC
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    chk("boot_req", 32'(bus.IMemReq), 32'h1);
    chk("boot_addr", bus.IMemAddr, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    chk("wait_valid", 32'(IF_Valid), 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    chk("f0_valid", 32'(IF_Valid), 32'h1);
    chk("f0_pc", IF_PC, 32'h0);
    chk("f0_pc4", IF_PCPlus4, 32'h4);
    chk("f0_instr", IF_Instr, 32'h0010_0093);
    chk("f0_next_addr", bus.IMemAddr, 32'h4);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    chk("f1_pc", IF_PC, 32'h4);

    // Stall while the response for 8 arrives
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    chk("hold_valid", 32'(IF_Valid), 32'h1);
    chk("hold_pc", IF_PC, 32'h4);
    chk("hold_instr", IF_Instr, memfn(32'h4));
    chk("hold_req", 32'(bus.IMemReq), 32'h0);
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    chk("hold2_pc", IF_PC, 32'h4);
    chk("hold2_req", 32'(bus.IMemReq), 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    chk("unskid_valid", 32'(IF_Valid), 32'h1);
    chk("unskid_pc", IF_PC, 32'h8);
    chk("unskid_pc4", IF_PCPlus4, 32'hC);
    chk("unskid_req", 32'(bus.IMemReq), 32'h1);
    chk("unskid_addr", bus.IMemAddr, 32'hC);

    // Redirect while waiting, response two cycles later
    mem_lat = 3;
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 1'b1, 32'h0000_0203, 1'b1);
    chk("rdr_valid", 32'(IF_Valid), 32'h0);
    chk("rdr_instr", IF_Instr, NOP_INSTR);
    chk("flush_req", 32'(bus.IMemReq), 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    chk("flush2_req", 32'(bus.IMemReq), 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    chk("rdr_req", 32'(bus.IMemReq), 32'h1);
    chk("rdr_addr", bus.IMemAddr, 32'h200);
    chk("rdr_dropped", 32'(IF_Valid), 32'h0);
    mem_lat = 1;
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    chk("tgt_pc", IF_PC, 32'h200);
    chk("tgt_instr", IF_Instr, memfn(32'h200));

    // Redirect + response + stall in one cycle, to the top word
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    drive(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
    chk("rrs_valid", 32'(IF_Valid), 32'h0);
    chk("rrs_instr", IF_Instr, NOP_INSTR);
    chk("rrs_skid", 32'(dut.skid_valid), 32'h0);
    chk("rrs_req", 32'(bus.IMemReq), 32'h1);
    chk("rrs_addr", bus.IMemAddr, 32'hFFFF_FFFC);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    chk("top_valid", 32'(IF_Valid), 32'h1);
    chk("top_pc", IF_PC, 32'hFFFF_FFFC);
    chk("top_pc4", IF_PCPlus4, 32'h0);
    chk("wrap_addr", bus.IMemAddr, 32'h0);

    // Reset while waiting, stale response lands in BOOT
    mem_lat = 3;
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    chk("mrst_req", 32'(bus.IMemReq), 32'h0);
    chk("mrst_valid", 32'(IF_Valid), 32'h0);
    chk("mrst_pc", IF_PC, 32'h0);
    chk("mrst_pc4", IF_PCPlus4, 32'h0);
    chk("mrst_instr", IF_Instr, NOP_INSTR);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    rst     = 1'b0;
    mem_lat = 1;
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    chk("stale_req", 32'(bus.IMemReq), 32'h1);
    chk("stale_addr", bus.IMemAddr, RESET_PC);
    chk("stale_valid", 32'(IF_Valid), 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    chk("rb_valid", 32'(IF_Valid), 32'h1);
    chk("rb_pc", IF_PC, RESET_PC);
    chk("rb_instr", IF_Instr, memfn(RESET_PC));

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      st  = ($urandom_range(0, 3) == 0);
      rd  = ($urandom_range(0, 39) == 0);
      rdy = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 3) == 0)
        rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else
        rpc = $urandom;
      mem_lat = $urandom_range(1, 3);
      drive(st, rd, rpc, rdy);
    end
    mem_lat = 1;
    for (int i = 0; i < 8; i++)
      drive(1'b0, 1'b0, 32'h0, 1'b1);

    vectors++;
    if (pops < 200) begin
      miscompares++;
      $display("FAIL throughput: %0d consumed, need >= 200", pops);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline.
- Holds the PC and issues one outstanding instruction-memory request at a time.
- Registers the returned instruction with its PC and PC+4 for the IF/ID boundary.
- The redirect target arrives from the EX-stage 32-bit branch/jump select mux. IF_PCPlus4 feeds the writeback select mux for JAL/JALR link values.

Parameters:
- RESET_PC, 32'h0000_0000, address of the first fetch after reset.
- NOP_INSTR, 32'h0000_0013, value IF_Instr takes on reset or flush (ADDI x0,x0,0).

Ports:
- clk  input  1  Single clock; all state updates on the rising edge.
- rst  input  1  Asynchronous, active-high reset.
- Stall  input  1  Hazard unit: hold the IF/ID outputs.
- Redirect  input  1  EX: branch taken or jump; flush and reload the PC.
- RedirectPC  input  32  EX: new PC from the branch/jump mux. Bits [1:0] are ignored.
- IMemReq  output  1  Request valid.
- IMemAddr  output  32  Request word address; [1:0] are always 0.
- IMemReady  input  1  Memory accepts the request this cycle.
- IMemRespValid  input  1  Response data valid.
- IMemRdata  input  32  Instruction word.
- IF_Valid  output  1  IF/ID holds a live instruction.
- IF_PC  output  32  PC of IF_Instr.
- IF_PCPlus4  output  32  IF_PC+4, modulo 2^32.
- IF_Instr  output  32  Fetched instruction.

Behaviour:
- Reset (async assert): pc=RESET_PC, state=BOOT, IF_Valid=0, IF_PC=0, IF_PCPlus4=0, IF_Instr=NOP_INSTR, skid buffer empty. IMemReq=0 while rst=1 and in BOOT.
- FSM states: BOOT, REQ, WAIT, HOLD, FLUSH.
  - BOOT -> REQ unconditionally on the first edge after reset release.
  - REQ: IMemReq=1, IMemAddr=pc. On IMemReady -> WAIT.
  - WAIT: on IMemRespValid, if the slot is free (IF_Valid=0 or Stall=0): load IF_PC=pc, IF_PCPlus4=pc+4, IF_Instr=IMemRdata, IF_Valid=1; set pc<=pc+4; -> REQ.
  - WAIT, slot busy (IMemRespValid=1, Stall=1, IF_Valid=1): capture {pc, IMemRdata} into the one-entry skid buffer; pc<=pc+4; -> HOLD.
  - HOLD: IMemReq=0. When Stall=0, move the skid buffer into the IF registers (IF_Valid=1) -> REQ.
  - FLUSH: IMemReq=0. Wait for IMemRespValid, discard the data -> REQ.
- IF register rule: when Stall=1, all IF_* outputs hold. When Stall=0 and no new instruction is loaded, IF_Valid<=0 (consumed); IF_PC, IF_PCPlus4 and IF_Instr hold.
- Redirect has highest priority, overriding Stall, any response and any state transition:
  - pc<=RedirectPC & ~32'h3; IF_Valid<=0; IF_Instr<=NOP_INSTR; skid buffer cleared.
  - Next state: FLUSH if a response is still owed, i.e. in WAIT without IMemRespValid that cycle, or in REQ with IMemReady that cycle.
  - Otherwise REQ; a response arriving in the Redirect cycle is discarded.
- Handshake: IMemReq/IMemAddr stay stable until accepted. The only exception is a Redirect cycle, where an unaccepted request may be withdrawn or retargeted. At most one request is outstanding.
- Throughput: with IMemReady=1 and a 1-cycle response, one instruction per 2 cycles. REQ-to-IF_Valid latency is 2 edges.
- Arithmetic: pc+4 wraps, so 32'hFFFF_FFFC -> 32'h0000_0000.
- Simultaneous events:
  - Stall with Redirect: Redirect wins.
  - Response with Redirect: the response is dropped.
  - Reset mid-transaction: everything returns to reset state; a late response while in BOOT is ignored.

Decomposition:
- riscv_pkg contains:
  - XLEN=32.
  - NOP_INSTR constant.
  - RESET_PC default.
  - fetch_state_t enum {BOOT, REQ, WAIT, HOLD, FLUSH}.
- Sub-module fetch_skid_buffer: one-entry buffer for {pc, instr} with load/unload/clear and a valid flag.
- PC register, FSM and IF registers remain in fetch_stage.

Test Plan:
- Reset release, memory with ready=1 and 1-cycle response returning 32'h0010_0093 at addr 0 -> IMemAddr=0, then IF_Valid=1, IF_PC=0, IF_PCPlus4=4, IF_Instr=32'h0010_0093; the next IMemAddr is 4.
- Stall=1 held 3 cycles while the response for addr 8 arrives with IF_Valid=1 -> the IF_* outputs for addr 4 are unchanged and the state is HOLD. After Stall drops: IF_PC=8 for one cycle, then IMemAddr=12.
- Redirect=1 with RedirectPC=32'h0000_0203 while in WAIT, response arriving 2 cycles later -> IF_Valid=0 and IF_Instr=NOP_INSTR. The response is discarded, then IMemAddr=32'h0000_0200.
- Redirect in the same cycle as IMemRespValid and Stall=1 -> no instruction is loaded, the skid buffer is empty, and the next request goes to the redirect target.
- Redirect to 32'hFFFF_FFFC -> IF_PC=32'hFFFF_FFFC, IF_PCPlus4=0, next IMemAddr=0.
- rst asserted while in WAIT, with a response arriving during BOOT -> all outputs take reset values, the response is ignored, and the first request goes to RESET_PC.
